// File: rtl/glitcbus_slave.sv
// GLITC-side slave for the TISC GAD bus: two address bytes, then either four
// write bytes into a local write strobe, or a turnaround and four read bytes.
module glitcbus_slave #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_b_i,
    input  logic        gsel_b_i,
    input  logic        grdwr_b_i,
    input  logic [7:0]  gad_i,
    output logic [7:0]  gad_o,
    output logic        gad_t_o,
    output logic [15:0] adr_o,
    output logic [31:0] dat_o,
    output logic        wr_o,
    output logic        rd_o,
    input  logic [31:0] rd_dat_i
);

    typedef enum logic [2:0] {IDLE, ADR1, WDAT, TURN, RDAT, WAIT} state_t;

    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_q, byte_d;
    logic [1:0]  turn_q, turn_d;
    logic        rnw_q, rnw_d;
    logic [23:0] rbuf_q, rbuf_d;   // read bytes 1..3, byte 0 goes straight to gad_o
    logic [7:0]  gad_d;
    logic        gad_t_d;
    logic [15:0] adr_d;
    logic [31:0] dat_d;
    logic        wr_d, rd_d;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        turn_d  = turn_q;
        rnw_d   = rnw_q;
        rbuf_d  = rbuf_q;
        gad_d   = gad_o;
        gad_t_d = 1'b1;
        adr_d   = adr_o;
        dat_d   = dat_o;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!gsel_b_i) begin
                    adr_d[7:0] = gad_i;
                    rnw_d      = grdwr_b_i;
                    state_d    = ADR1;
                end
            end
            ADR1: begin
                if (gsel_b_i) begin
                    state_d = IDLE;
                end else begin
                    adr_d[15:8] = gad_i;
                    byte_d      = '0;
                    turn_d      = '0;
                    if (rnw_q) begin
                        state_d = TURN;
                        rd_d    = (TURN_LAST == 2'd0);
                    end else begin
                        state_d = WDAT;
                    end
                end
            end
            WDAT: begin
                if (gsel_b_i) begin
                    byte_d  = '0;
                    state_d = IDLE;
                end else begin
                    dat_d[{byte_q, 3'b000} +: 8] = gad_i;
                    if (byte_q == 2'd3) begin
                        byte_d  = '0;
                        wr_d    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            TURN: begin
                // rd_o is raised on entry to the last turnaround cycle so the
                // capture below lands on the edge that closes that cycle.
                if (gsel_b_i) begin
                    turn_d  = '0;
                    state_d = IDLE;
                end else if (turn_q == TURN_LAST) begin
                    gad_d   = rd_dat_i[7:0];
                    rbuf_d  = rd_dat_i[31:8];
                    gad_t_d = 1'b0;
                    byte_d  = '0;
                    turn_d  = '0;
                    state_d = RDAT;
                end else begin
                    turn_d = turn_q + 2'd1;
                    rd_d   = ((turn_q + 2'd1) == TURN_LAST);
                end
            end
            RDAT: begin
                if (gsel_b_i) begin
                    byte_d  = '0;
                    state_d = IDLE;
                end else if (byte_q == 2'd3) begin
                    byte_d  = '0;
                    state_d = WAIT;
                end else begin
                    gad_d   = rbuf_q[{byte_q, 3'b000} +: 8];
                    gad_t_d = 1'b0;
                    byte_d  = byte_q + 2'd1;
                end
            end
            WAIT: begin
                if (gsel_b_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
            byte_q  <= '0;
            turn_q  <= '0;
            rnw_q   <= 1'b0;
            rbuf_q  <= '0;
            gad_o   <= '0;
            gad_t_o <= 1'b1;
            adr_o   <= '0;
            dat_o   <= '0;
            wr_o    <= 1'b0;
            rd_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            turn_q  <= turn_d;
            rnw_q   <= rnw_d;
            rbuf_q  <= rbuf_d;
            gad_o   <= gad_d;
            gad_t_o <= gad_t_d;
            adr_o   <= adr_d;
            dat_o   <= dat_d;
            wr_o    <= wr_d;
            rd_o    <= rd_d;
        end
    end

endmodule
